// File: rtl/branch_comparator.sv
// ---------------------------------------------------------------------------
// branch_comparator
//   Branch-condition comparator for the execute stage of the RV32 pipeline.
//   Reports equality and less-than of two register operands. Less-than is
//   either unsigned or two's-complement, chosen per compare by s. Branch
//   control builds BEQ/BNE/BLT/BGE/BLTU/BGEU from eq and lt.
//
//   The magnitude compare is a tree. Each 4-bit group produces an eq/lt
//   pair, and the pairs are merged two at a time. Sign handling is applied
//   only at the root.
//
// Parameters
//   WIDTH    operand width in bits (>= 2)
//   REG_OUT  1: eq/lt registered, 1-cycle latency; 0: combinational
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   rs1d   in   WIDTH  operand A
//   rs2d   in   WIDTH  operand B
//   s      in   1      1 = signed less-than, 0 = unsigned less-than
//   eq     out  1      rs1d == rs2d
//   lt     out  1      rs1d <  rs2d in the selected mode
// ---------------------------------------------------------------------------
module branch_comparator #(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic             s,
  output logic             eq,
  output logic             lt
);

  // Operands are zero-padded up to whole 4-bit groups. The tree is sized
  // to a power of two so the pairwise merge is a perfect binary heap.
  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;
  localparam int NP = 1 << $clog2(NG);

  logic [PW-1:0] aPad;
  logic [PW-1:0] bPad;
  logic          eqU;
  logic          ltU;
  logic          signDiff;
  logic          eqC;
  logic          ltC;

  assign aPad = PW'(rs1d);
  assign bPad = PW'(rs2d);

  // Heap-ordered compare tree. Node n has its more-significant child at 2n
  // and its less-significant child at 2n+1. Leaf NP+j holds group NP-1-j,
  // so j=0 is the most significant group. Leaves past the real groups act
  // as "equal" and therefore never influence the result.
  always_comb begin : compareTree
    logic       eqN [1:2*NP-1];
    logic       ltN [1:2*NP-1];
    logic [3:0] ga;
    logic [3:0] gb;
    logic [3:0] bitEq;
    logic [3:0] bitLt;
    int         g;
    ga    = 4'b0;
    gb    = 4'b0;
    bitEq = 4'b0;
    bitLt = 4'b0;
    g     = 0;
    for (int n = 1; n < 2*NP; n++) begin
      eqN[n] = 1'b1;
      ltN[n] = 1'b0;
    end
    for (int j = 0; j < NP; j++) begin
      g = NP - 1 - j;
      if (g < NG) begin
        ga    = aPad[g*4 +: 4];
        gb    = bPad[g*4 +: 4];
        bitEq = ~(ga ^ gb);
        bitLt = ~ga & gb;
        // The first differing bit from the top of the group decides lt.
        ltN[NP+j] = bitLt[3]
                  | (bitEq[3] & bitLt[2])
                  | (bitEq[3] & bitEq[2] & bitLt[1])
                  | (bitEq[3] & bitEq[2] & bitEq[1] & bitLt[0]);
        eqN[NP+j] = &bitEq;
      end
    end
    for (int n = NP - 1; n >= 1; n--) begin
      ltN[n] = ltN[2*n] | (eqN[2*n] & ltN[2*n+1]);
      eqN[n] = eqN[2*n] & eqN[2*n+1];
    end
    eqU = eqN[1];
    ltU = ltN[1];
  end

  // When the signs differ, the negative operand is the smaller one. When
  // the signs match, the sign bits are equal, so the full-width unsigned
  // result is the same as the compare of the low bits.
  assign signDiff = rs1d[WIDTH-1] ^ rs2d[WIDTH-1];
  assign eqC      = eqU;
  assign ltC      = (s & signDiff) ? rs1d[WIDTH-1] : ltU;

  if (REG_OUT) begin : gReg
    logic eq_q;
    logic lt_q;
    logic eq_d;
    logic lt_d;

    assign eq_d = eqC;
    assign lt_d = ltC;

    // Output register. Reset clears any held result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        eq_q <= 1'b0;
        lt_q <= 1'b0;
      end else begin
        eq_q <= eq_d;
        lt_q <= lt_d;
      end
    end

    assign eq = eq_q;
    assign lt = lt_q;
  end else begin : gComb
    // Clock and reset are present only to keep the port list uniform.
    logic unusedClkRst;
    assign unusedClkRst = clk & rst_n;
    assign eq = eqC;
    assign lt = ltC;
  end

endmodule

// File: tb/tb_branch_comparator.sv
// ---------------------------------------------------------------------------
// tb_branch_comparator
//   Self-checking bench for branch_comparator with WIDTH=32 and REG_OUT=1.
//
//   The driver applies a vector at each negedge and queues the expected
//   eq/lt. The monitor pops one entry just after each posedge while the
//   queue is non-empty, because results appear one edge after the inputs
//   are driven.
//
//   Reset and hold behaviour is checked directly while the queue is empty.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_branch_comparator;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        eq;
    logic        lt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1d;
  logic [31:0] rs2d;
  logic        s;
  logic        eq;
  logic        lt;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  branch_comparator #(.WIDTH(32), .REG_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1d  (rs1d),
    .rs2d  (rs2d),
    .s     (s),
    .eq    (eq),
    .lt    (lt)
  );

  // 20 ns clock period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Immediate check of the outputs against a required pair.
  task automatic checkOutput(input string name, input logic expEq, input logic expLt);
    vecCount++;
    if (eq !== expEq || lt !== expLt) begin
      missCount++;
      $display("[TB] FAIL %s: got eq=%b lt=%b, required eq=%b lt=%b",
               name, eq, lt, expEq, expLt);
    end
  endtask

  // Drive one vector at the negedge and queue its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sv, input logic expEq, input logic expLt);
    exp_t e;
    @(negedge clk);
    rs1d = a;
    rs2d = b;
    s    = sv;
    e.a  = a;
    e.b  = b;
    e.sv = sv;
    e.eq = expEq;
    e.lt = expLt;
    expQ.push_back(e);
  endtask

  // Wait, with a bounded number of cycles, for the monitor to consume
  // every queued vector.
  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while (expQ.size() > 0 && cyc < 50) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    vecCount++;
    if (expQ.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drainTimeout: got %0d entries pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: compare the registered result just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      vecCount++;
      if (eq !== e.eq || lt !== e.lt) begin
        missCount++;
        $display("[TB] FAIL vec a=%h b=%h s=%b: got eq=%b lt=%b, required eq=%b lt=%b",
                 e.a, e.b, e.sv, eq, lt, e.eq, e.lt);
      end
    end
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence.
  initial begin
    rst_n = 1'b1;
    rs1d  = 32'h0;
    rs2d  = 32'h0;
    s     = 1'b0;
    #1 rst_n = 1'b0;
    #1 checkOutput("resetState", 1'b0, 1'b0);

    // Equal operands while held in reset: the outputs must stay cleared
    // across an edge.
    rs1d = 32'h5;
    rs2d = 32'h5;
    @(posedge clk);
    #1 checkOutput("resetHeldAcrossEdge", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    applyStimulus(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1234_5679, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_0010, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hA5A5_0000, 32'hA5A4_FFFF, 1'b0, 1'b0, 1'b0);

    // Walking one in rs2d against zero exercises every group. Zero is
    // less than every 1<<k, except 1<<31 in signed mode, which is negative.
    for (int k = 0; k < 32; k++) begin
      applyStimulus(32'h0, 32'h1 << k, 1'b0, 1'b0, 1'b1);
      applyStimulus(32'h0, 32'h1 << k, 1'b1, 1'b0, (k == 31) ? 1'b0 : 1'b1);
    end
    waitDrain();

    // A registered result is held while the inputs change between edges.
    applyStimulus(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    waitDrain();
    #1;
    rs1d = 32'h1;
    rs2d = 32'h2;
    #1 checkOutput("holdBetweenEdges", 1'b1, 1'b0);

    // An asynchronous reset clears the held result without a clock edge.
    #1 rst_n = 1'b0;
    #1 checkOutput("asyncResetMid", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("resetRelease", 1'b0, 1'b1);

    // Back-to-back vectors after the reset.
    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
